// File: rtl/spi_master_pkg.sv
// Shared definitions for the register-access SPI master: frame layout, FSM states and
// the motor-controller register map.
package spi_master_pkg;

    localparam int unsigned FrameLen = 16;
    localparam int unsigned WrBit    = 15;
    localparam int unsigned AddrMsb  = 11;
    localparam int unsigned AddrLsb  = 8;
    localparam int unsigned DataMsb  = 7;
    localparam int unsigned DataLsb  = 0;

    localparam int unsigned BitCntW  = 4;
    localparam int unsigned DivCntW  = 8;
    localparam int unsigned GapCntW  = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } spi_state_e;

    localparam logic [3:0] RegCtrl      = 4'h0;
    localparam logic [3:0] RegStatus    = 4'h1;
    localparam logic [3:0] RegMode      = 4'h2;
    localparam logic [3:0] RegDutyA     = 4'h3;
    localparam logic [3:0] RegDutyB     = 4'h4;
    localparam logic [3:0] RegDutyC     = 4'h5;
    localparam logic [3:0] RegDeadTime  = 4'h6;
    localparam logic [3:0] RegPwmPeriod = 4'h7;
    localparam logic [3:0] RegCurLimit  = 4'h8;
    localparam logic [3:0] RegSpeedLo   = 4'h9;
    localparam logic [3:0] RegSpeedHi   = 4'hA;
    localparam logic [3:0] RegPosLo     = 4'hB;
    localparam logic [3:0] RegPosHi     = 4'hC;
    localparam logic [3:0] RegFault     = 4'hD;
    localparam logic [3:0] RegFaultMask = 4'hE;
    localparam logic [3:0] RegDevId     = 4'hF;

    function automatic logic [FrameLen-1:0] build_frame(input logic       wr,
                                                        input logic [3:0] addr,
                                                        input logic [7:0] wrdata);
        logic [FrameLen-1:0] f;
        f = '0;
        f[WrBit] = wr;
        f[AddrMsb:AddrLsb] = addr;
        if (wr) begin
            f[DataMsb:DataLsb] = wrdata;
        end
        return f;
    endfunction

endpackage

// File: rtl/spi_master_clkdiv.sv
// Half-period tick generator for the SPI master; counts 0..ClkDiv-1 and pulses tick_o on
// the last count.
module spi_clkdiv
    import spi_master_pkg::*;
#(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam logic [DivCntW-1:0] LastCnt = DivCntW'(ClkDiv - 1);

    logic [DivCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = (cnt_q == LastCnt);
        cnt_d  = tick_o ? '0 : cnt_q + DivCntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master issuing 16-bit register read/write frames to the motor controller.
// All pins come straight from flops; a gap of 2*CLKDIV cycles follows every frame.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wrdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rddata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam logic [GapCntW-1:0] GapLast = GapCntW'(2 * CLKDIV - 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(FrameLen - 1);
    // Rises following bit counts 7..14 carry frame bits 7:0 (the read data).
    localparam logic [BitCntW-1:0] RxFirst = BitCntW'(7);

    spi_state_e           state_q;
    logic [BitCntW-1:0]   bit_cnt_q;
    logic [GapCntW-1:0]   gap_cnt_q;
    logic [FrameLen-2:0]  tx_q;
    logic [7:0]           rx_q;
    logic [7:0]           rddata_q;
    logic                 ss_q, sclk_q, mosi_q, busy_q, done_q;

    logic [FrameLen-1:0]  frame;
    logic                 div_rst;
    logic                 tick;

    always_comb begin
        frame   = build_frame(wr, addr, wrdata);
        div_rst = reset || !(state_q inside {StSetup, StShift});
    end

    spi_clkdiv #(
        .ClkDiv (CLKDIV)
    ) u_clkdiv (
        .clk_i  (clk),
        .rst_i  (div_rst),
        .tick_o (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rddata_q  <= '0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StSetup;
                        ss_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        mosi_q    <= frame[FrameLen-1];
                        tx_q      <= frame[FrameLen-2:0];
                        bit_cnt_q <= '0;
                    end
                end
                StSetup: begin
                    if (tick) begin
                        state_q <= StShift;
                        sclk_q  <= 1'b1;
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            mosi_q <= tx_q[FrameLen-2];
                            tx_q   <= {tx_q[FrameLen-3:0], 1'b0};
                        end else if (bit_cnt_q == LastBit) begin
                            state_q   <= StGap;
                            ss_q      <= 1'b1;
                            mosi_q    <= 1'b0;
                            done_q    <= 1'b1;
                            rddata_q  <= rx_q;
                            bit_cnt_q <= '0;
                            gap_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                            sclk_q    <= 1'b1;
                            if (bit_cnt_q >= RxFirst) begin
                                rx_q <= {rx_q[6:0], miso};
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapCntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rddata = rddata_q;
    assign ss     = ss_q;
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: CLKDIV=4 and CLKDIV=2 instances share one mode-0 slave
// model through a select mux.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b1;
    logic       wr = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] wrdata = 8'h00;
    logic       sel = 1'b0;

    logic       start_a, start_b;
    logic       busy_a, done_a, ss_a, sclk_a, mosi_a;
    logic       busy_b, done_b, ss_b, sclk_b, mosi_b;
    logic [7:0] rddata_a, rddata_b;

    logic       ss_m, sclk_m, mosi_m, busy_m, done_m;
    logic [7:0] rddata_m;
    logic       miso_m = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign start_a  = start & ~sel;
    assign start_b  = start & sel;
    assign ss_m     = sel ? ss_b : ss_a;
    assign sclk_m   = sel ? sclk_b : sclk_a;
    assign mosi_m   = sel ? mosi_b : mosi_a;
    assign busy_m   = sel ? busy_b : busy_a;
    assign done_m   = sel ? done_b : done_a;
    assign rddata_m = sel ? rddata_b : rddata_a;

    spi_master #(.CLKDIV(4)) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .start  (start_a),
        .wr     (wr),
        .addr   (addr),
        .wrdata (wrdata),
        .busy   (busy_a),
        .done   (done_a),
        .rddata (rddata_a),
        .ss     (ss_a),
        .sclk   (sclk_a),
        .mosi   (mosi_a),
        .miso   (miso_m)
    );

    spi_master #(.CLKDIV(2)) u_dut2 (
        .clk    (clk),
        .reset  (reset),
        .start  (start_b),
        .wr     (wr),
        .addr   (addr),
        .wrdata (wrdata),
        .busy   (busy_b),
        .done   (done_b),
        .rddata (rddata_b),
        .ss     (ss_b),
        .sclk   (sclk_b),
        .mosi   (mosi_b),
        .miso   (miso_m)
    );

    // Mode-0 slave: presents the response on ss fall and after each sclk fall,
    // captures mosi on each sclk rise.
    logic [7:0]  resp_byte = 8'h00;
    logic [15:0] s_frame = 16'h0;
    logic [15:0] mosi_cap = 16'h0;
    logic        s_act = 1'b0;
    int          nrise = 0;
    int          nframe = 0;

    always @(ss_m or sclk_m) begin
        if (ss_m) begin
            s_act  = 1'b0;
            miso_m = 1'b0;
        end else if (!s_act) begin
            s_act    = 1'b1;
            s_frame  = {8'h00, resp_byte};
            miso_m   = s_frame[15];
            mosi_cap = 16'h0;
            nrise    = 0;
            nframe   = nframe + 1;
        end else if (sclk_m) begin
            mosi_cap = {mosi_cap[14:0], mosi_m};
            nrise    = nrise + 1;
        end else begin
            s_frame = {s_frame[14:0], 1'b0};
            miso_m  = s_frame[15];
        end
    end

    int   cyc = 0;
    int   cur_low = 0, last_low = 0, cur_high = 0, last_high = 0;
    int   last_rise = 0, sclk_period = 0;
    logic sclk_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ss_m) begin
            cur_high <= cur_high + 1;
            if (cur_low != 0) begin
                last_low <= cur_low;
                cur_low  <= 0;
            end
        end else begin
            cur_low <= cur_low + 1;
            if (cur_high != 0) begin
                last_high <= cur_high;
                cur_high  <= 0;
            end
        end
        if (sclk_m && !sclk_prev) begin
            sclk_period <= cyc - last_rise;
            last_rise   <= cyc;
        end
        sclk_prev <= sclk_m;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one frame from a negedge and returns at the negedge where busy is first low.
    task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] resp, input logic [15:0] exp_stream,
                        input int exp_low, input int poke_mid);
        int         ndone;
        int         gap_k;
        logic [7:0] rd;
        logic       fin;
        ndone = 0;
        gap_k = -100;
        rd = 8'h00;
        fin = 1'b0;
        resp_byte = resp;
        wr = w;
        addr = a;
        wrdata = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr = ~w;
        addr = ~a;
        wrdata = ~d;
        check_eq("first ss", ss_m, 1'b0);
        check_eq("first busy", busy_m, 1'b1);
        check_eq("first mosi", mosi_m, w);
        for (int k = 0; k < 400; k++) begin
            if (done_m) begin
                ndone++;
                rd = rddata_m;
                gap_k = k;
                check_eq("done ss", ss_m, 1'b1);
                check_eq("done sclk", sclk_m, 1'b0);
                check_eq("done mosi", mosi_m, 1'b0);
            end
            if (!busy_m) begin
                fin = 1'b1;
                break;
            end
            start = (k == poke_mid) || (poke_mid >= 0 && k == gap_k + 2);
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("timeout", fin, 1'b1);
        check_eq("done count", ndone, 1);
        check_eq("mosi stream", mosi_cap, exp_stream);
        check_eq("sclk rises", nrise, 16);
        check_eq("rddata", rd, resp);
        check_eq("ss low time", last_low, exp_low);
    endtask

    initial begin
        int f0;
        int nd;
        // Reset held with start high: start must be ignored.
        repeat (3) @(negedge clk);
        check_eq("rst ss", ss_m, 1'b1);
        check_eq("rst sclk", sclk_m, 1'b0);
        check_eq("rst mosi", mosi_m, 1'b0);
        check_eq("rst busy", busy_m, 1'b0);
        check_eq("rst done", done_m, 1'b0);
        check_eq("rst rddata", rddata_m, 8'h00);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("start w/ reset busy", busy_m, 1'b0);
        check_eq("start w/ reset ss", ss_m, 1'b1);

        xfer(1'b1, 4'h2, 8'hA5, 8'h5A, 16'h82A5, 132, -1);
        check_eq("rddata hold", rddata_m, 8'h5A);
        xfer(1'b0, 4'hD, 8'hFF, 8'h3C, 16'h0D00, 132, -1);

        // Starts mid-frame and during the gap must be ignored.
        f0 = nframe;
        xfer(1'b1, 4'h7, 8'h96, 8'h11, 16'h8796, 132, 60);
        repeat (12) @(negedge clk);
        check_eq("ignored start busy", busy_m, 1'b0);
        check_eq("ignored start frames", nframe - f0, 1);

        // Abort during bit 9.
        resp_byte = 8'hAA;
        wr = 1'b0;
        addr = 4'h5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 300 && nrise != 10; k++) @(negedge clk);
        check_eq("abort reached bit9", nrise, 10);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort ss", ss_m, 1'b1);
        check_eq("abort sclk", sclk_m, 1'b0);
        check_eq("abort busy", busy_m, 1'b0);
        reset = 1'b0;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_m) nd++;
            @(negedge clk);
        end
        check_eq("abort no done", nd, 0);
        check_eq("abort rddata", rddata_m, 8'h00);
        xfer(1'b1, 4'h4, 8'hC3, 8'h99, 16'h84C3, 132, -1);

        // Back-to-back: second start in the first idle cycle.
        xfer(1'b0, 4'h9, 8'h00, 8'h42, 16'h0900, 132, -1);
        xfer(1'b1, 4'hB, 8'h5C, 8'hE7, 16'h8B5C, 132, -1);
        check_eq("b2b ss high", last_high, 9);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        xfer(1'b0, 4'h0, 8'h00, 8'h81, 16'h0000, 66, -1);
        check_eq("div2 period a0", sclk_period, 4);
        xfer(1'b0, 4'h1, 8'h00, 8'h7E, 16'h0100, 66, -1);
        check_eq("div2 period a1", sclk_period, 4);
        xfer(1'b0, 4'hF, 8'h00, 8'hC3, 16'h0F00, 66, -1);
        check_eq("div2 period aF", sclk_period, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
